// File: rtl/cache_set_array.sv
// Set-associative tag/data array with PLRU replacement, single-cycle refill,
// optional write-back dirty tracking and a sequential flush engine.
module cache_set_array #(
   parameter int IDX_W      = 5,
   parameter int TAG_W      = 3,
   parameter int OFF_W      = 2,
   parameter int WAYS       = 2,
   parameter int WRITE_BACK = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   input  logic                           req_write,
   input  logic [IDX_W-1:0]               req_index,
   input  logic [TAG_W-1:0]               req_tag,
   input  logic [OFF_W-1:0]               req_offset,
   input  logic [31:0]                    req_wdata,
   input  logic [3:0]                     req_be,
   input  logic                           refill,
   input  logic [32*(2**OFF_W)-1:0]       refill_data,
   input  logic                           flush_start,
   output logic                           ready,
   output logic                           rsp_valid,
   output logic                           rsp_hit,
   output logic [$clog2(WAYS)-1:0]        rsp_way,
   output logic [31:0]                    rsp_rdata,
   output logic                           victim_valid,
   output logic [TAG_W-1:0]               victim_tag,
   output logic [32*(2**OFF_W)-1:0]       victim_data,
   output logic                           busy
);

   localparam int SETS   = 2**IDX_W;
   localparam int WORDS  = 2**OFF_W;
   localparam int LINE_W = 32*WORDS;
   localparam int WAY_W  = $clog2(WAYS);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Tree-PLRU helpers; the 2-way case only uses bit 0.
   function automatic logic [1:0] plru_victim(input logic [2:0] p);
      if (WAYS == 4) begin
         plru_victim = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
      end else begin
         plru_victim = {1'b0, p[0]};
      end
   endfunction

   function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
      plru_touch = p;
      if (WAYS == 4) begin
         plru_touch[0] = ~w[1];
         if (w[1]) begin
            plru_touch[2] = ~w[0];
         end else begin
            plru_touch[1] = ~w[0];
         end
      end else begin
         plru_touch[0] = ~w[0];
      end
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      for (int k = 0; k < 4; k++) begin
         merge_bytes[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
      end
   endfunction

   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [2:0]        r_plru  [SETS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [31:0]       r_data  [SETS][WAYS][WORDS];

   state_t            r_state;
   logic [IDX_W-1:0]  r_cnt;
   logic              r_busy;

   logic              r_rsp_valid;
   logic              r_rsp_hit;
   logic [WAY_W-1:0]  r_rsp_way;
   logic [31:0]       r_rsp_rdata;
   logic              r_victim_valid;
   logic [TAG_W-1:0]  r_victim_tag;
   logic [LINE_W-1:0] r_victim_data;

   logic [WAYS-1:0]   w_set_valid;
   logic [WAYS-1:0]   w_match;
   logic              w_hit;
   logic [WAY_W-1:0]  w_hit_way;
   logic [WAY_W-1:0]  w_tgt_way;
   logic [31:0]       w_hit_word;
   logic [LINE_W-1:0] w_victim_line;
   logic              w_victim_dirty;
   logic              w_accept;
   logic              w_do_refill;
   logic              w_flushing;

   assign w_flushing  = (r_state == ST_FLUSH);
   assign ready       = ~r_busy & ~refill;
   assign w_accept    = req_valid & ready;
   assign w_do_refill = refill & ~r_busy;

   // Tag compare and refill target: lowest invalid way wins over the PLRU pick.
   always_comb begin
      w_set_valid = r_valid[req_index];
      w_match     = {WAYS{1'b0}};
      w_hit_way   = {WAY_W{1'b0}};
      w_tgt_way   = WAY_W'(plru_victim(r_plru[req_index]));
      for (int w = WAYS - 1; w >= 0; w--) begin
         w_match[w] = w_set_valid[w] & (r_tag[req_index][w] == req_tag);
         w_hit_way  = w_hit_way | (w_match[w] ? WAY_W'(w) : {WAY_W{1'b0}});
         w_tgt_way  = w_set_valid[w] ? w_tgt_way : WAY_W'(w);
      end
      w_hit      = |w_match;
      w_hit_word = r_data[req_index][w_hit_way][req_offset];
   end

   // Old contents of the refill target, reported only if it held dirty data.
   always_comb begin
      w_victim_line = {LINE_W{1'b0}};
      for (int k = 0; k < WORDS; k++) begin
         w_victim_line[32*k +: 32] = r_data[req_index][w_tgt_way][k];
      end
      w_victim_dirty = (WRITE_BACK != 0) & w_set_valid[w_tgt_way]
                       & r_dirty[req_index][w_tgt_way];
   end

   // Flush sequencer: walks one set per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= {IDX_W{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flush_start) begin
                  r_state <= ST_FLUSH;
                  r_cnt   <= {IDX_W{1'b0}};
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (r_cnt == {IDX_W{1'b1}}) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= {IDX_W{1'b0}};
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= {IDX_W{1'b0}};
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Line state: valid, dirty and PLRU; flush, refill and hits are mutually exclusive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= {WAYS{1'b0}};
            r_dirty[s] <= {WAYS{1'b0}};
            r_plru[s]  <= 3'b000;
         end
      end else if (w_flushing) begin
         r_valid[r_cnt] <= {WAYS{1'b0}};
         r_dirty[r_cnt] <= {WAYS{1'b0}};
         r_plru[r_cnt]  <= 3'b000;
      end else if (w_do_refill) begin
         r_valid[req_index][w_tgt_way] <= 1'b1;
         r_dirty[req_index][w_tgt_way] <= 1'b0;
         r_plru[req_index] <= plru_touch(r_plru[req_index], 2'(w_tgt_way));
      end else if (w_accept && w_hit) begin
         r_plru[req_index] <= plru_touch(r_plru[req_index], 2'(w_hit_way));
         if (req_write && (WRITE_BACK != 0)) begin
            r_dirty[req_index][w_hit_way] <= 1'b1;
         end
      end
   end

   // Tag and data storage, deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_do_refill) begin
         r_tag[req_index][w_tgt_way] <= req_tag;
         for (int k = 0; k < WORDS; k++) begin
            r_data[req_index][w_tgt_way][k] <= refill_data[32*k +: 32];
         end
      end else if (w_accept && w_hit && req_write) begin
         r_data[req_index][w_hit_way][req_offset] <= merge_bytes(w_hit_word, req_wdata, req_be);
      end
   end

   // Registered lookup response and victim report.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_valid    <= 1'b0;
         r_rsp_hit      <= 1'b0;
         r_rsp_way      <= {WAY_W{1'b0}};
         r_rsp_rdata    <= 32'h0000_0000;
         r_victim_valid <= 1'b0;
         r_victim_tag   <= {TAG_W{1'b0}};
         r_victim_data  <= {LINE_W{1'b0}};
      end else begin
         r_rsp_valid    <= w_accept;
         r_rsp_hit      <= w_accept & w_hit;
         r_rsp_way      <= (w_accept & w_hit) ? w_hit_way : {WAY_W{1'b0}};
         r_rsp_rdata    <= (w_accept & w_hit) ? w_hit_word : 32'h0000_0000;
         r_victim_valid <= w_do_refill & w_victim_dirty;
         if (w_do_refill && w_victim_dirty) begin
            r_victim_tag  <= r_tag[req_index][w_tgt_way];
            r_victim_data <= w_victim_line;
         end
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_hit      = r_rsp_hit;
   assign rsp_way      = r_rsp_way;
   assign rsp_rdata    = r_rsp_rdata;
   assign victim_valid = r_victim_valid;
   assign victim_tag   = r_victim_tag;
   assign victim_data  = r_victim_data;
   assign busy         = r_busy;

endmodule

// File: tb/tb_cache_set_array.sv
// Directed plus random stimulus for cache_set_array (2-way, write-back),
// checked against a per-way LRU reference model.
module tb_cache_set_array;

   localparam int IDX_W = 5;
   localparam int TAG_W = 3;
   localparam int OFF_W = 2;
   localparam int WAYS  = 2;
   localparam int WB    = 1;
   localparam int SETS  = 32;
   localparam int LINE_W = 128;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_write;
   logic [IDX_W-1:0]  req_index;
   logic [TAG_W-1:0]  req_tag;
   logic [OFF_W-1:0]  req_offset;
   logic [31:0]       req_wdata;
   logic [3:0]        req_be;
   logic              refill;
   logic [LINE_W-1:0] refill_data;
   logic              flush_start;
   logic              ready;
   logic              rsp_valid;
   logic              rsp_hit;
   logic [0:0]        rsp_way;
   logic [31:0]       rsp_rdata;
   logic              victim_valid;
   logic [TAG_W-1:0]  victim_tag;
   logic [LINE_W-1:0] victim_data;
   logic              busy;

   int checks;
   int failures;

   cache_set_array #(
      .IDX_W(IDX_W), .TAG_W(TAG_W), .OFF_W(OFF_W), .WAYS(WAYS), .WRITE_BACK(WB)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_index(req_index),
      .req_tag(req_tag), .req_offset(req_offset), .req_wdata(req_wdata),
      .req_be(req_be), .refill(refill), .refill_data(refill_data),
      .flush_start(flush_start), .ready(ready), .rsp_valid(rsp_valid),
      .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_rdata(rsp_rdata),
      .victim_valid(victim_valid), .victim_tag(victim_tag),
      .victim_data(victim_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-way state plus the least-recently-used way of each set.
   bit          m_valid [SETS][WAYS];
   bit          m_dirty [SETS][WAYS];
   logic [2:0]  m_tag   [SETS][WAYS];
   logic [31:0] m_data  [SETS][WAYS][4];
   int          m_lru   [SETS];
   int          m_flush_left;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
         m_lru[s] = 0;
      end
      m_flush_left = 0;
   endtask

   function automatic bit tag_present(input int idx, input int tag);
      tag_present = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[idx][w] && m_tag[idx][w] == tag) tag_present = 1'b1;
   endfunction

   // One clock cycle: predict, drive, clock, compare. Entered just after a rising edge.
   task automatic step(input bit v, input bit wr, input int idx, input int tag, input int off,
                       input logic [31:0] wd, input logic [3:0] be,
                       input bit rf, input logic [127:0] line, input bit fl);
      bit busy_b, acc, e_hit, e_vv;
      int e_way, t;
      logic [31:0] e_rd;
      logic [2:0] e_vt;
      logic [127:0] e_vd;
      busy_b = (m_flush_left > 0);
      acc = v && !busy_b && !rf;
      e_hit = 1'b0; e_way = 0; e_rd = 32'h0; e_vv = 1'b0; e_vt = 3'h0; e_vd = '0;
      if (acc) begin
         for (int w = 0; w < WAYS; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
               e_hit = 1'b1; e_way = w;
            end
         if (e_hit) begin
            e_rd = m_data[idx][e_way][off];
            m_lru[idx] = 1 - e_way;
            if (wr) begin
               for (int k = 0; k < 4; k++)
                  if (be[k]) m_data[idx][e_way][off][8*k +: 8] = wd[8*k +: 8];
               if (WB != 0) m_dirty[idx][e_way] = 1'b1;
            end
         end
      end
      if (rf && !busy_b) begin
         t = -1;
         for (int w = 0; w < WAYS; w++)
            if (!m_valid[idx][w] && t < 0) t = w;
         if (t < 0) t = m_lru[idx];
         if (WB != 0 && m_valid[idx][t] && m_dirty[idx][t]) begin
            e_vv = 1'b1;
            e_vt = m_tag[idx][t];
            for (int k = 0; k < 4; k++) e_vd[32*k +: 32] = m_data[idx][t][k];
         end
         m_valid[idx][t] = 1'b1;
         m_dirty[idx][t] = 1'b0;
         m_tag[idx][t] = 3'(tag);
         for (int k = 0; k < 4; k++) m_data[idx][t][k] = line[32*k +: 32];
         m_lru[idx] = 1 - t;
      end
      if (busy_b) m_flush_left--;
      else if (fl) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               m_valid[s][w] = 1'b0;
               m_dirty[s][w] = 1'b0;
            end
            m_lru[s] = 0;
         end
         m_flush_left = SETS;
      end

      req_valid = v; req_write = wr; req_index = IDX_W'(idx); req_tag = TAG_W'(tag);
      req_offset = OFF_W'(off); req_wdata = wd; req_be = be;
      refill = rf; refill_data = line; flush_start = fl;
      #1;
      chk("ready", ready, !busy_b && !rf);
      @(posedge clk);
      #1;
      chk("rsp_valid", rsp_valid, acc);
      if (acc) begin
         chk("rsp_hit", rsp_hit, e_hit);
         chk("rsp_way", rsp_way, e_way);
         chk("rsp_rdata", rsp_rdata, e_rd);
      end
      chk("victim_valid", victim_valid, e_vv);
      if (e_vv) begin
         chk("victim_tag", victim_tag, e_vt);
         chk("victim_data", victim_data, e_vd);
      end
      chk("busy", busy, m_flush_left > 0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 0, 32'h0, 4'h0, 1'b0, '0, 1'b0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_hit", rsp_hit, 1'b0);
      chk("rst_rsp_way", rsp_way, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_victim_valid", victim_valid, 1'b0);
      chk("rst_victim_tag", victim_tag, 3'h0);
      chk("rst_victim_data", victim_data, 128'h0);
      chk("rst_busy", busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbusy, idx, tag, r;
      logic [127:0] line;
      checks = 0; failures = 0;
      req_valid = 1'b0; req_write = 1'b0; req_index = '0; req_tag = '0;
      req_offset = '0; req_wdata = 32'h0; req_be = 4'h0;
      refill = 1'b0; refill_data = '0; flush_start = 1'b0;
      reset = 1'b0;
      model_reset();
      #12;
      check_reset_outputs();
      @(posedge clk); #1;
      reset = 1'b1;

      // Cold miss, refill, read hit, partial write, read-after-write.
      step(1'b1, 1'b0, 3, 5, 0, 32'h0, 4'h0, 1'b0, '0, 1'b0);
      chk("cold_miss_hit", rsp_hit, 1'b0);
      chk("cold_miss_rdata", rsp_rdata, 32'h0);
      step(1'b0, 1'b0, 3, 5, 0, 32'h0, 4'h0, 1'b1,
           {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
      step(1'b1, 1'b0, 3, 5, 2, 32'h0, 4'h0, 1'b0, '0, 1'b0);
      chk("read_hit_way", rsp_way, 1'b0);
      chk("read_hit_rdata", rsp_rdata, 32'h33);
      step(1'b1, 1'b1, 3, 5, 1, 32'hAABBCCDD, 4'b0011, 1'b0, '0, 1'b0);
      chk("write_prewrite_rdata", rsp_rdata, 32'h22);
      step(1'b1, 1'b0, 3, 5, 1, 32'h0, 4'h0, 1'b0, '0, 1'b0);
      chk("raw_rdata", rsp_rdata, 32'h0000CCDD);

      // Dirty eviction through PLRU.
      step(1'b0, 1'b0, 0, 1, 0, 32'h0, 4'h0, 1'b1, {4{32'h1111_0001}}, 1'b0);
      step(1'b0, 1'b0, 0, 2, 0, 32'h0, 4'h0, 1'b1, {4{32'h2222_0002}}, 1'b0);
      step(1'b1, 1'b1, 0, 1, 3, 32'hDEADBEEF, 4'b1111, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 0, 2, 0, 32'h0, 4'h0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 0, 3, 0, 32'h0, 4'h0, 1'b1, {4{32'h3333_0003}}, 1'b0);
      chk("evict_valid", victim_valid, 1'b1);
      chk("evict_tag", victim_tag, 3'd1);
      idle();

      // Flush with a same-cycle refill, then ignored flush/refill while busy.
      step(1'b0, 1'b0, 5, 4, 0, 32'h0, 4'h0, 1'b1, {4{32'h5555_0004}}, 1'b1);
      nbusy = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < 36; i++) begin
         step(1'b1, 1'b0, i % SETS, 5, 0, 32'h0, 4'h0, (i % 3) == 0, {4{32'h7777_0000}},
              (i % 5) == 0 && i < 30);
         if (busy === 1'b1) nbusy++;
      end
      chk("flush_busy_cycles", nbusy, 32);
      step(1'b1, 1'b0, 3, 5, 1, 32'h0, 4'h0, 1'b0, '0, 1'b0);
      chk("post_flush_miss", rsp_hit, 1'b0);

      // Random traffic on a few sets so hits, evictions and flushes interleave.
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 199);
         idx = $urandom_range(0, 3);
         tag = $urandom_range(0, 7);
         line = {$urandom, $urandom, $urandom, $urandom};
         if (r < 1)
            step(1'b0, 1'b0, idx, tag, 0, 32'h0, 4'h0, 1'b0, '0, 1'b1);
         else if (r < 45 && !tag_present(idx, tag))
            step($urandom_range(0, 1) == 1, 1'b0, idx, tag, 0, 32'h0, 4'h0, 1'b1, line, 1'b0);
         else
            step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, idx, tag,
                 $urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)), 1'b0, '0, 1'b0);
      end
      while (m_flush_left > 0) idle();

      // Reset in the middle of a flush.
      step(1'b0, 1'b0, 0, 0, 0, 32'h0, 4'h0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) idle();
      #2;
      reset = 1'b0;
      model_reset();
      #2;
      check_reset_outputs();
      @(posedge clk); #1;
      reset = 1'b1;
      step(1'b1, 1'b0, 3, 5, 0, 32'h0, 4'h0, 1'b0, '0, 1'b0);
      chk("post_reset_miss", rsp_hit, 1'b0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_set_array.md
CACHE_SET_ARRAY -- requirements
Module: cache_set_array

Interface
REQ-001 Parameter IDX_W, default 5, index width; number of sets is 2^IDX_W.
REQ-002 Parameter TAG_W, default 3, tag width.
REQ-003 Parameter OFF_W, default 2, word-offset width; line is 2^OFF_W 32-bit words (LINE_W = 32*2^OFF_W).
REQ-004 Parameter WAYS, default 2, associativity; legal values 2 or 4 only.
REQ-005 Parameter WRITE_BACK, default 0; 0 means write-through (no dirty tracking), 1 means write-back (per-line dirty bit).
REQ-006 Ports, in order (name, direction, width, meaning):
 clk  in  1  clock, rising-edge.
 reset  in  1  asynchronous, active-low reset.
 req_valid  in  1  lookup request.
 req_write  in  1  request is a word write (else read).
 req_index  in  IDX_W  set index.
 req_tag  in  TAG_W  tag.
 req_offset  in  OFF_W  word within line.
 req_wdata  in  32  write data.
 req_be  in  4  byte enables; bit k covers bits 8k+7:8k.
 refill  in  1  install line at req_index/req_tag.
 refill_data  in  LINE_W  line from main memory; word 0 in bits 31:0.
 flush_start  in  1  invalidate all lines.
 ready  out  1  request accepted this cycle when high with req_valid.
 rsp_valid  out  1  lookup result valid.
 rsp_hit  out  1  lookup hit.
 rsp_way  out  log2(WAYS)  hitting way.
 rsp_rdata  out  32  read word (hit only; else 0).
 victim_valid  out  1  dirty line evicted (WRITE_BACK=1 only).
 victim_tag  out  TAG_W  evicted tag.
 victim_data  out  LINE_W  evicted line.
 busy  out  1  flush in progress.

Function
REQ-007 Storage per set per way: valid, tag, line data, dirty (WRITE_BACK=1); per set: PLRU bits (1 for 2-way, 3 for 4-way).
REQ-008 ready = ~busy & ~refill; request accepted when req_valid & ready.
REQ-009 Lookup latency 1 cycle: accepted in cycle N -> rsp_valid high for exactly cycle N+1 with rsp_hit/rsp_way/rsp_rdata; rsp_valid low otherwise.
REQ-010 Hit = some way with valid=1 and tag equal req_tag; at most one way matches; rsp_way = that way, 0 on miss.
REQ-011 Write hit: selected word updated at edge ending cycle N, only bytes with req_be set; rsp_rdata returns pre-write word; dirty set if WRITE_BACK=1, never set if 0.
REQ-012 Write miss: no array change (no-write-allocate); read miss: no array change.
REQ-013 Any hit updates PLRU of that set; misses do not.
REQ-014 PLRU 2-way: bit = way to replace; access to way w sets bit = ~w.
REQ-015 PLRU 4-way: b0 selects half, b1 low half, b2 high half; access to w sets b0=~w[1], and b1=~w[0] if w[1]=0 else b2=~w[0]; victim = {0,b1} if b0=0 else {1,b2}.
REQ-016 Refill (single cycle, priority over requests): target way = lowest-numbered invalid way, else PLRU victim; writes refill_data, tag, valid=1, dirty=0; updates PLRU as an access to target way.
REQ-017 If WRITE_BACK=1 and target way was valid and dirty, victim_valid pulses high the cycle after refill with old tag/data; else victim_valid stays 0.
REQ-018 Flush FSM states IDLE, FLUSH. IDLE: flush_start -> FLUSH, counter=0, busy=1. FLUSH: clears valid, dirty, PLRU of set counter each cycle; after set 2^IDX_W-1 -> IDLE, busy=0. Duration exactly 2^IDX_W cycles.
REQ-019 flush_start during FLUSH is ignored; refill during FLUSH is ignored; flush_start and refill same cycle in IDLE: refill performed, flush starts.
REQ-020 Same-set read in cycle after a write hit returns the written data.

Reset
REQ-021 reset low asynchronously clears all valid, dirty, PLRU bits, FSM to IDLE, counter 0, and rsp_valid, rsp_hit, rsp_way, rsp_rdata, victim_valid, victim_tag, victim_data, busy to 0; line data not reset.
REQ-022 Reset asserted mid-flush aborts flush; after release block is IDLE with all lines invalid.

Verification
REQ-023 After reset, read idx 3 tag 5 -> next cycle rsp_valid=1, rsp_hit=0, rsp_rdata=0.
REQ-024 Refill idx 3 tag 5 data words 0x11,0x22,0x33,0x44; read offset 2 -> rsp_hit=1, rsp_way=0, rsp_rdata=0x33.
REQ-025 Write hit idx 3 offset 1 data 0xAABBCCDD be=0011, then read -> rsp_rdata=0x0000CCDD (old 0x22 upper bytes zero).
REQ-026 WAYS=2, WRITE_BACK=1: refill tags 1,2 into idx 0, write hit tag 1, read tag 2, refill tag 3 -> tag 1 evicted, victim_valid=1, victim_tag=1.
REQ-027 flush_start -> busy=1 for 32 cycles, ready=0; then every read misses.
